exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
Multi-cycle control FSM that fetches 16-bit instruction words, decodes them and drives the 8-bit ALU/execution unit. It performs register-file writeback, holds the architectural S/Z/C/O flag register and updates the program counter, including taken conditional jumps. It sits between the instruction memory, the register file and the execution unit, and is the only block that sequences that unit.

Parameters:
PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = leave IDLE/HALT and execute
imem_req  out  1  fetch request; held high until imem_valid
imem_addr  out  PC_W  fetch address (= pc)
imem_valid  in  1  instruction word valid; sampled only while imem_req=1
imem_data  in  16  instruction word
rf_raddr1  out  3  register read port 1 address (= instr[10:8], rd)
rf_raddr2  out  3  register read port 2 address (= instr[7:5], rs)
rf_waddr  out  3  write address (= rd)
rf_we  out  1  single-cycle write strobe
alu_op  out  5  opcode to the execution unit (= instr[15:11])
alu_imm  out  3  shift/rotate amount (= instr[2:0])
jump_addr  out  8  jump target / LI immediate (= instr[7:0])
alu_cjump  in  1  ConditionalJump from the execution unit
alu_s, alu_z, alu_c, alu_o  in  1 each  flags from the execution unit
flag_s, flag_z, flag_c, flag_o  out  1 each  registered flags, fed back as Sin/Zin/Cin/Oin
pc  out  PC_W  program counter
busy  out  1  1 in FETCH/DECODE/EXEC/WB
halted  out  1  1 in HALT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instruction register=16'h0000 (alu_op=NOP), all flags=0, imem_req=0, rf_we=0, busy=0, halted=0. Reset takes effect mid-instruction: a pending fetch is abandoned and no writeback occurs.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: if run=1, go to FETCH on the next edge; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc. When imem_valid=1, latch imem_data into the instruction register and go to DECODE. If imem_valid stays 0, remain in FETCH indefinitely with imem_req held.
- DECODE: drive the rf read addresses. alu_op stays NOP, so the unit holds flags.
- EXEC: alu_op = decoded opcode. This is one settle cycle for the combinational unit.
- WB (one cycle):
  - Flags are captured from alu_s/z/c/o for every opcode except HALT.
  - rf_we=1 for opcodes 00001–01000, 01001–01110, 01111, 10000, 10100 and 11101.
  - rf_we=0 for NOP, CMP (10110), SHOWR/SHOWRR, jumps (10111–11100) and HALT.
  - If alu_cjump=1 and the opcode is in 10111–11100, pc ← jump_addr. Otherwise pc ← pc+1, wrapping FF→00.
  - Next state: HALT if the opcode is 10001; else FETCH if run=1; else IDLE.
- HALT: hold pc (already incremented past the HALT instruction). Leave for FETCH only on a rising edge of run (run sampled 0 then 1). halted=1.
- Latency: 4 cycles per instruction with a zero-wait fetch (FETCH, DECODE, EXEC, WB). Each extra imem wait cycle adds 1.
- Outputs are registered or decoded from state plus the instruction register only. There are no combinational paths from imem_data to the ALU.
- run dropping to 0 mid-instruction takes effect only at WB; the current instruction always completes.

Test Plan:
- Reset: assert rst_n=0 during EXEC -> immediately pc=00, state=IDLE, rf_we=0, flags=0, imem_req=0.
- ADD: with run=1 and imem_data=16'h0920 (ADD r1,r1) returned with zero wait -> rf_we pulses in cycle 4 with rf_waddr=1, pc 00→01, and the next imem_req at cycle 5.
- Fetch stall: delay imem_valid by 3 cycles -> imem_req stays high for 4 cycles, imem_addr is stable, and WB occurs at cycle 7.
- JE taken: set flag_z=1, fetch opcode 10111 with jump_addr=8'h40, alu_cjump=1 -> pc=40, rf_we=0. With alu_cjump=0 -> pc=pc+1.
- HALT: fetch 16'h8800 at pc=05 -> halted=1, pc=06. Holding run=1 keeps it halted; a run 0→1 resumes the fetch at 06.
- Wrap/CMP: pc=FF with CMP (10110) -> flags updated, rf_we=0, pc=00.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit execution unit.
// Owns the instruction register, the program counter and the architectural S/Z/C/O flags.
module exec_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [2:0]      rf_raddr1,
  output logic [2:0]      rf_raddr2,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic [4:0]      alu_op,
  output logic [2:0]      alu_imm,
  output logic [7:0]      jump_addr,
  input  logic            alu_cjump,
  input  logic            alu_s,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_o,
  output logic            flag_s,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_o,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b10001;

  state_t          state_q, state_d;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc_q;
  logic            run_q;
  logic [4:0]      op;
  logic            op_writes_rf;
  logic            op_is_jump;
  logic            take_jump;

  assign op = ir_q[15:11];

  always_comb begin
    op_writes_rf = ((op >= 5'd1) && (op <= 5'd16)) || (op == 5'd20) || (op == 5'd29);
    op_is_jump   = (op >= 5'd23) && (op <= 5'd28);
    take_jump    = op_is_jump && alu_cjump;
  end

  // Fetch handshake: imem_req is high for the whole FETCH state; the word is
  // taken on the first edge where imem_valid=1 while imem_req=1, never otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (op == OP_HALT) state_d = S_HALT;
        else if (run)      state_d = S_FETCH;
        else               state_d = S_IDLE;
      end
      S_HALT:   if (run && !run_q) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
      pc_q    <= RESET_PC;
      run_q   <= 1'b0;
      flag_s  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      if (state_q == S_FETCH && imem_valid) ir_q <= imem_data;
      if (state_q == S_WB) begin
        if (op != OP_HALT) begin
          flag_s <= alu_s;
          flag_z <= alu_z;
          flag_c <= alu_c;
          flag_o <= alu_o;
        end
        if (take_jump) pc_q <= PC_W'(ir_q[7:0]);
        else           pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  // The unit sees the real opcode only in EXEC/WB so it holds flags in DECODE.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    rf_raddr1 = ir_q[10:8];
    rf_raddr2 = ir_q[7:5];
    rf_waddr  = ir_q[10:8];
    rf_we     = (state_q == S_WB) && op_writes_rf;
    alu_op    = (state_q == S_EXEC || state_q == S_WB) ? op : OP_NOP;
    alu_imm   = ir_q[2:0];
    jump_addr = ir_q[7:0];
    pc        = pc_q;
    busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                (state_q == S_EXEC)  || (state_q == S_WB);
    halted    = (state_q == S_HALT);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: hand-computed vectors checked with immediate assertions.
module tb_exec_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DEC   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic [2:0]  rf_waddr;
  logic        rf_we;
  logic [4:0]  alu_op;
  logic [2:0]  alu_imm;
  logic [7:0]  jump_addr;
  logic        alu_cjump;
  logic        alu_s, alu_z, alu_c, alu_o;
  logic        flag_s, flag_z, flag_c, flag_o;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [2:0]  dbg_state;

  int vectors;
  int miscompares;

  exec_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .alu_op(alu_op), .alu_imm(alu_imm), .jump_addr(jump_addr), .alu_cjump(alu_cjump),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_o(alu_o),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_o(flag_o),
    .pc(pc), .busy(busy), .halted(halted), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock edge; inputs are driven and outputs sampled at the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // starts in FETCH with a zero-wait fetch, returns while in WB
  task automatic fetch_exec(input logic [15:0] word);
    imem_data  = word;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    tick();
    check("in_wb", 32'(dbg_state), 32'(ST_WB));
  endtask

  task automatic set_alu_flags(input logic [3:0] szco);
    {alu_s, alu_z, alu_c, alu_o} = szco;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    alu_cjump  = 1'b0;
    set_alu_flags(4'b0000);
    tick();
    tick();

    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_we", 32'(rf_we), 32'h0);
    check("rst_aluop", 32'(alu_op), 32'h0);
    check("rst_flags", 32'({flag_s, flag_z, flag_c, flag_o}), 32'h0);

    rst_n = 1'b1;
    tick();
    check("idle_hold", 32'(dbg_state), 32'(ST_IDLE));

    // ADD r1,r1 with zero-wait fetch
    run        = 1'b1;
    imem_data  = 16'h0920;
    imem_valid = 1'b1;
    set_alu_flags(4'b0010);
    tick();
    check("add_c1_req", 32'(imem_req), 32'h1);
    check("add_c1_addr", 32'(imem_addr), 32'h00);
    check("add_c1_busy", 32'(busy), 32'h1);
    tick();
    imem_valid = 1'b0;
    check("add_c2_aluop", 32'(alu_op), 32'h00);
    check("add_c2_raddr1", 32'(rf_raddr1), 32'h1);
    check("add_c2_raddr2", 32'(rf_raddr2), 32'h1);
    check("add_c2_we", 32'(rf_we), 32'h0);
    tick();
    check("add_c3_aluop", 32'(alu_op), 32'h01);
    check("add_c3_we", 32'(rf_we), 32'h0);
    tick();
    check("add_c4_we", 32'(rf_we), 32'h1);
    check("add_c4_waddr", 32'(rf_waddr), 32'h1);
    check("add_c4_pc", 32'(pc), 32'h00);
    tick();
    check("add_c5_req", 32'(imem_req), 32'h1);
    check("add_c5_pc", 32'(pc), 32'h01);
    check("add_c5_we", 32'(rf_we), 32'h0);
    check("add_c5_flag_c", 32'(flag_c), 32'h1);

    // fetch stall of 3 cycles, opcode 00010 rd=3
    imem_data = 16'h1300;
    set_alu_flags(4'b0100);
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 32'(imem_req), 32'h1);
      check("stall_addr", 32'(imem_addr), 32'h01);
      tick();
    end
    check("stall_req4", 32'(imem_req), 32'h1);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    check("stall_c5_dec", 32'(dbg_state), 32'(ST_DEC));
    tick();
    tick();
    check("stall_c7_wb", 32'(dbg_state), 32'(ST_WB));
    check("stall_we", 32'(rf_we), 32'h1);
    check("stall_waddr", 32'(rf_waddr), 32'h3);
    tick();
    check("stall_pc", 32'(pc), 32'h02);
    check("stall_flags", 32'({flag_s, flag_z, flag_c, flag_o}), 32'h4);

    // JE taken to 0x40
    alu_cjump = 1'b1;
    fetch_exec(16'hB840);
    check("je_t_we", 32'(rf_we), 32'h0);
    check("je_t_jaddr", 32'(jump_addr), 32'h40);
    tick();
    check("je_t_pc", 32'(pc), 32'h40);
    check("je_t_flag_z", 32'(flag_z), 32'h1);

    // JE not taken
    alu_cjump = 1'b0;
    fetch_exec(16'hB840);
    check("je_nt_we", 32'(rf_we), 32'h0);
    tick();
    check("je_nt_pc", 32'(pc), 32'h41);

    // jump to 0x05, then HALT; flags must not follow the unit on HALT
    alu_cjump = 1'b1;
    fetch_exec(16'hB805);
    tick();
    check("jmp5_pc", 32'(pc), 32'h05);
    alu_cjump = 1'b0;
    set_alu_flags(4'b1111);
    fetch_exec(16'h8800);
    check("halt_we", 32'(rf_we), 32'h0);
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h06);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_req", 32'(imem_req), 32'h0);
    check("halt_flags", 32'({flag_s, flag_z, flag_c, flag_o}), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_hold_run1", 32'(dbg_state), 32'(ST_HALT));
    end
    run = 1'b0;
    tick();
    check("halt_hold_run0", 32'(dbg_state), 32'(ST_HALT));
    run = 1'b1;
    tick();
    check("halt_resume", 32'(dbg_state), 32'(ST_FETCH));
    check("halt_resume_addr", 32'(imem_addr), 32'h06);
    check("halt_resume_halted", 32'(halted), 32'h0);

    // jump to 0xFF, then CMP wraps pc and ignores cjump
    alu_cjump = 1'b1;
    fetch_exec(16'hB8FF);
    tick();
    check("jmpff_pc", 32'(pc), 32'hFF);
    set_alu_flags(4'b1011);
    fetch_exec(16'hB220);
    check("cmp_we", 32'(rf_we), 32'h0);
    tick();
    check("cmp_pc_wrap", 32'(pc), 32'h00);
    check("cmp_flags", 32'({flag_s, flag_z, flag_c, flag_o}), 32'hB);

    // run drops mid-instruction: LI-class 10100 rd=5 completes, then IDLE
    alu_cjump  = 1'b0;
    imem_data  = 16'hA533;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    run        = 1'b0;
    tick();
    tick();
    check("drop_wb_we", 32'(rf_we), 32'h1);
    check("drop_wb_waddr", 32'(rf_waddr), 32'h5);
    tick();
    check("drop_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("drop_pc", 32'(pc), 32'h01);
    check("drop_busy", 32'(busy), 32'h0);

    // asynchronous reset during EXEC
    run        = 1'b1;
    imem_data  = 16'h0920;
    imem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    tick();
    check("mid_exec", 32'(dbg_state), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_we", 32'(rf_we), 32'h0);
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_aluop", 32'(alu_op), 32'h0);
    check("arst_flags", 32'({flag_s, flag_z, flag_c, flag_o}), 32'h0);
    tick();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
